// File: rtl/rv_decode_stage_pkg.sv
// Shared types for the RV32I decode stage: ALU/memory encodings, opcodes and
// the decoded bundle carried from decode into execute.
package rv_pkg;

    // Wide enough for any supported XLEN; the stage keeps the low XLEN bits.
    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SUB  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_SRA  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SLT  = 4'b1011,
        ALU_SLTU = 4'b1100
    } alu_ops_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } memsize_t;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] imm;
        alu_ops_t            aluop;
        logic [1:0]          alusrc;
        logic                regwrite;
        logic                memtoreg;
        logic                memread;
        logic                memwrite;
        logic                branch;
        logic                jump;
        memsize_t            memsize;
        logic                memunsigned;
        logic [2:0]          brfunct3;
        logic                illegal;
    } decode_bundle_t;

    function automatic decode_bundle_t reset_bundle(input logic [XLEN_MAX-1:0] pc);
        decode_bundle_t b;
        b         = '0;
        b.pc      = pc;
        b.aluop   = ALU_ADD;
        b.memsize = MEM_WORD;
        return b;
    endfunction

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch-side, execute-side and interlock signals of the decode stage; the
// stage itself uses the slave view.
interface rv_decode_stage_if #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_instr;
    logic [XLEN-1:0]    in_pc;
    logic               flush;
    logic               ex_load_valid;
    logic [4:0]         ex_load_rd;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [4:0]         out_rs1;
    logic [4:0]         out_rs2;
    logic [4:0]         out_rd;
    logic [XLEN-1:0]    out_imm;
    logic [ALUOP_W-1:0] out_aluop;
    logic [1:0]         out_alusrc;
    logic               out_regwrite;
    logic               out_memtoreg;
    logic               out_memread;
    logic               out_memwrite;
    logic               out_branch;
    logic               out_jump;
    logic [1:0]         out_memsize;
    logic               out_memunsigned;
    logic [2:0]         out_brfunct3;
    logic               out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, ex_load_valid, ex_load_rd, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_aluop,
               out_alusrc, out_regwrite, out_memtoreg, out_memread, out_memwrite,
               out_branch, out_jump, out_memsize, out_memunsigned, out_brfunct3, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, ex_load_valid, ex_load_rd, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_aluop,
               out_alusrc, out_regwrite, out_memtoreg, out_memread, out_memwrite,
               out_branch, out_jump, out_memsize, out_memunsigned, out_brfunct3, out_illegal
    );

endinterface

// File: rtl/rv_decode_stage_comb.sv
// Purely combinational RV32I decoder: raw instruction to decoded bundle, plus
// which source registers the instruction actually reads.
module rv_decode_comb
    import rv_pkg::*;
(
    input  logic [31:0]         instr,
    input  logic [XLEN_MAX-1:0] pc,
    output decode_bundle_t      dec,
    output logic                rs1_used,
    output logic                rs2_used
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [XLEN_MAX-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec         = '0;
        dec.pc      = pc;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.aluop   = ALU_ADD;
        dec.memsize = MEM_WORD;
        rs1_used    = 1'b1;
        rs2_used    = 1'b0;

        case (opcode)
            OP_OP: begin
                rs2_used     = 1'b1;
                dec.regwrite = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec.aluop = ALU_ADD;
                    {7'b0100000, 3'b000}: dec.aluop = ALU_SUB;
                    {7'b0000000, 3'b001}: dec.aluop = ALU_SLL;
                    {7'b0000000, 3'b010}: dec.aluop = ALU_SLT;
                    {7'b0000000, 3'b011}: dec.aluop = ALU_SLTU;
                    {7'b0000000, 3'b100}: dec.aluop = ALU_XOR;
                    {7'b0000000, 3'b101}: dec.aluop = ALU_SRL;
                    {7'b0100000, 3'b101}: dec.aluop = ALU_SRA;
                    {7'b0000000, 3'b110}: dec.aluop = ALU_OR;
                    {7'b0000000, 3'b111}: dec.aluop = ALU_AND;
                    default:              dec.illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 2'b01;
                dec.imm      = imm_i;
                case (funct3)
                    3'b000: dec.aluop = ALU_ADD;
                    3'b010: dec.aluop = ALU_SLT;
                    3'b011: dec.aluop = ALU_SLTU;
                    3'b100: dec.aluop = ALU_XOR;
                    3'b110: dec.aluop = ALU_OR;
                    3'b111: dec.aluop = ALU_AND;
                    3'b001: begin
                        dec.aluop   = ALU_SLL;
                        dec.illegal = (funct7 != 7'b0000000);
                    end
                    default: begin
                        // funct3 101: funct7 selects logical vs arithmetic shift
                        if (funct7 == 7'b0000000)      dec.aluop = ALU_SRL;
                        else if (funct7 == 7'b0100000) dec.aluop = ALU_SRA;
                        else                           dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_LOAD: begin
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.alusrc   = 2'b01;
                dec.imm      = imm_i;
                case (funct3)
                    3'b000:  dec.memsize = MEM_BYTE;
                    3'b001:  dec.memsize = MEM_HALF;
                    3'b010:  dec.memsize = MEM_WORD;
                    3'b100: begin dec.memsize = MEM_BYTE; dec.memunsigned = 1'b1; end
                    3'b101: begin dec.memsize = MEM_HALF; dec.memunsigned = 1'b1; end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                rs2_used     = 1'b1;
                dec.memwrite = 1'b1;
                dec.alusrc   = 2'b01;
                dec.imm      = imm_s;
                case (funct3)
                    3'b000:  dec.memsize = MEM_BYTE;
                    3'b001:  dec.memsize = MEM_HALF;
                    3'b010:  dec.memsize = MEM_WORD;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                rs2_used     = 1'b1;
                dec.branch   = 1'b1;
                dec.aluop    = ALU_SUB;
                dec.brfunct3 = funct3;
                dec.imm      = imm_b;
                dec.illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL: begin
                rs1_used     = 1'b0;
                dec.jump     = 1'b1;
                dec.regwrite = 1'b1;
                dec.imm      = imm_j;
            end
            OP_JALR: begin
                dec.jump     = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 2'b01;
                dec.imm      = imm_i;
                dec.illegal  = (funct3 != 3'b000);
            end
            OP_LUI, OP_AUIPC: begin
                rs1_used     = 1'b0;
                dec.regwrite = 1'b1;
                dec.alusrc   = 2'b10;
                dec.imm      = imm_u;
            end
            default: dec.illegal = 1'b1;
        endcase

        // An illegal bundle must not disturb architectural or memory state.
        if (dec.illegal) begin
            dec.regwrite = 1'b0;
            dec.memtoreg = 1'b0;
            dec.memread  = 1'b0;
            dec.memwrite = 1'b0;
            dec.branch   = 1'b0;
            dec.jump     = 1'b0;
        end
        if (dec.rd == 5'd0) dec.regwrite = 1'b0;
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: one-entry output register with valid/ready on
// both sides, load-use interlock and branch-redirect flush.
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              ALUOP_W   = 4,
    parameter int              HAZARD_EN = 1,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input logic           clk,
    input logic           reset,
    rv_decode_stage_if.slave bus
);

    decode_bundle_t dec;
    decode_bundle_t q;
    logic           out_valid_q;
    logic           rs1_used;
    logic           rs2_used;
    logic           hazard;
    logic           accept;
    logic           unused_bits;

    rv_decode_comb u_decode (
        .instr    (bus.in_instr),
        .pc       (XLEN_MAX'(bus.in_pc)),
        .dec      (dec),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    // Load-use: the instruction at the input reads a register still being loaded.
    always_comb begin
        hazard = (HAZARD_EN != 0) && bus.ex_load_valid && (bus.ex_load_rd != 5'd0) &&
                 ((rs1_used && (bus.ex_load_rd == dec.rs1)) ||
                  (rs2_used && (bus.ex_load_rd == dec.rs2)));
    end

    assign bus.in_ready = (~out_valid_q | bus.out_ready) & ~hazard & ~reset;
    assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            q           <= reset_bundle(XLEN_MAX'(RESET_PC));
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            q           <= dec;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.out_pc          = q.pc[XLEN-1:0];
    assign bus.out_rs1         = q.rs1;
    assign bus.out_rs2         = q.rs2;
    assign bus.out_rd          = q.rd;
    assign bus.out_imm         = q.imm[XLEN-1:0];
    assign bus.out_aluop       = ALUOP_W'(q.aluop);
    assign bus.out_alusrc      = q.alusrc;
    assign bus.out_regwrite    = q.regwrite;
    assign bus.out_memtoreg    = q.memtoreg;
    assign bus.out_memread     = q.memread;
    assign bus.out_memwrite    = q.memwrite;
    assign bus.out_branch      = q.branch;
    assign bus.out_jump        = q.jump;
    assign bus.out_memsize     = q.memsize;
    assign bus.out_memunsigned = q.memunsigned;
    assign bus.out_brfunct3    = q.brfunct3;
    assign bus.out_illegal     = q.illegal;

    // Upper pc/imm bits beyond XLEN are carried in the shared bundle but unused.
    assign unused_bits = ^{q.pc, q.imm};

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: reset, streaming, load-use interlock,
// backpressure, flush and a table of decode/immediate vectors.
module tb_rv_decode_stage;
    import rv_pkg::*;

    localparam int              XLEN     = 32;
    localparam int              ALUOP_W  = 4;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0080;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic        chk_imm;
        logic        chk_full;
        logic [3:0]  aluop;
        logic [1:0]  alusrc;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jp;
        logic [1:0]  ms;
        logic        mu;
        logic [2:0]  bf3;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [0:10];

    always #5 clk = ~clk;

    rv_decode_stage_if #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) bus ();

    rv_decode_stage #(
        .XLEN(XLEN), .ALUOP_W(ALUOP_W), .HAZARD_EN(1), .RESET_PC(RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = 32'h002081B3; bus.in_pc = 32'h100; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%0h want=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got=%0h want=0", bus.in_ready); end
        checks++; if (bus.out_aluop !== 4'b0000) begin errors++; $display("[TB] FAIL reset_aluop got=%0h want=0", bus.out_aluop); end
        checks++; if (bus.out_pc !== RESET_PC) begin errors++; $display("[TB] FAIL reset_pc got=%0h want=%0h", bus.out_pc, RESET_PC); end
        checks++; if (bus.out_memsize !== 2'b10) begin errors++; $display("[TB] FAIL reset_memsize got=%0h want=2", bus.out_memsize); end
        checks++; if (bus.out_imm !== 32'h0) begin errors++; $display("[TB] FAIL reset_imm got=%0h want=0", bus.out_imm); end
        checks++; if ({bus.out_regwrite, bus.out_memread, bus.out_memwrite, bus.out_jump} !== 4'b0) begin errors++; $display("[TB] FAIL reset_ctrl got=%0h want=0", {bus.out_regwrite, bus.out_memread, bus.out_memwrite, bus.out_jump}); end
        reset = 1'b0; bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got=%0h want=1", bus.in_ready); end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = 32'h402081B3; bus.in_pc = 32'h200;
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sub_valid got=%0h want=1", bus.out_valid); end
        checks++; if (bus.out_aluop !== 4'b0010) begin errors++; $display("[TB] FAIL sub_aluop got=%0h want=2", bus.out_aluop); end
        checks++; if (bus.out_rd !== 5'd3) begin errors++; $display("[TB] FAIL sub_rd got=%0d want=3", bus.out_rd); end
        checks++; if (bus.out_pc !== 32'h200) begin errors++; $display("[TB] FAIL sub_pc got=%0h want=200", bus.out_pc); end
        bus.in_instr = 32'h00812283; bus.in_pc = 32'h204;
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL lw_valid got=%0h want=1", bus.out_valid); end
        checks++; if ({bus.out_memread, bus.out_memtoreg} !== 2'b11) begin errors++; $display("[TB] FAIL lw_mem got=%0h want=3", {bus.out_memread, bus.out_memtoreg}); end
        checks++; if (bus.out_memsize !== 2'b10) begin errors++; $display("[TB] FAIL lw_memsize got=%0h want=2", bus.out_memsize); end
        checks++; if (bus.out_imm !== 32'd8) begin errors++; $display("[TB] FAIL lw_imm got=%0h want=8", bus.out_imm); end
        checks++; if (bus.out_alusrc !== 2'b01) begin errors++; $display("[TB] FAIL lw_alusrc got=%0h want=1", bus.out_alusrc); end
        checks++; if (bus.out_rd !== 5'd5) begin errors++; $display("[TB] FAIL lw_rd got=%0d want=5", bus.out_rd); end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_bubble got=%0h want=0", bus.out_valid); end
    endtask

    task automatic test_load_use();
        bus.out_ready = 1'b1;
        bus.ex_load_valid = 1'b1; bus.ex_load_rd = 5'd5;
        bus.in_valid = 1'b1; bus.in_instr = 32'h00128333; bus.in_pc = 32'h300;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hazard_in_ready got=%0h want=0", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hazard_valid cycle=%0d got=%0h want=0", i, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hazard_hold cycle=%0d got=%0h want=0", i, bus.in_ready); end
        end
        bus.ex_load_valid = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hazard_release got=%0h want=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hazard_accept got=%0h want=1", bus.out_valid); end
        checks++; if ({bus.out_rd, bus.out_pc} !== {5'd6, 32'h300}) begin errors++; $display("[TB] FAIL hazard_rd_pc got=%0d/%0h want=6/300", bus.out_rd, bus.out_pc); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hazard_once got=%0h want=0", bus.out_valid); end
        // rs2 field of an I-type is immediate bits, so it must not interlock
        bus.ex_load_valid = 1'b1; bus.ex_load_rd = 5'd1; bus.in_instr = 32'h00128313;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL itype_rs2_unused got=%0h want=1", bus.in_ready); end
        bus.ex_load_rd = 5'd0; bus.in_instr = 32'h00000033;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_no_hazard got=%0h want=1", bus.in_ready); end
        bus.ex_load_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = 32'h00812283; bus.in_pc = 32'h400;
        tick();
        bus.out_ready = 1'b0; bus.in_instr = 32'h402081B3; bus.in_pc = 32'h404;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got=%0h want=0", bus.in_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid cycle=%0d got=%0h want=1", i, bus.out_valid); end
            checks++; if ({bus.out_pc, bus.out_memread} !== {32'h400, 1'b1}) begin errors++; $display("[TB] FAIL bp_stable cycle=%0d got=%0h/%0h want=400/1", i, bus.out_pc, bus.out_memread); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold cycle=%0d got=%0h want=0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if ({bus.out_valid, bus.out_pc, bus.out_aluop} !== {1'b1, 32'h404, 4'b0010}) begin errors++; $display("[TB] FAIL bp_next got=%0h/%0h/%0h want=1/404/2", bus.out_valid, bus.out_pc, bus.out_aluop); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup got=%0h want=0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = 32'h402081B3; bus.in_pc = 32'h500;
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_valid got=%0h want=1", bus.out_valid); end
        bus.out_ready = 1'b0; bus.flush = 1'b1; bus.in_instr = 32'h00812283; bus.in_pc = 32'h504;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_held got=%0h want=0", bus.out_valid); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready got=%0h want=1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_drop_incoming got=%0h want=0", bus.out_valid); end
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_after got=%0h want=0", bus.out_valid); end
    endtask

    task automatic test_decode_table();
        vecs[0]  = '{32'h123450B7, 32'h12345000, 1'b1, 1'b1, ALU_ADD, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, ALU_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000, 1'b1};
        vecs[2]  = '{32'hFE209EE3, 32'hFFFFFFFC, 1'b1, 1'b1, 4'b0010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 3'b001, 1'b0};
        vecs[3]  = '{32'h0040C283, 32'h00000004, 1'b1, 1'b1, ALU_ADD, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'b000, 1'b0};
        vecs[4]  = '{32'h0040B283, 32'h00000000, 1'b0, 1'b0, ALU_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000, 1'b1};
        vecs[5]  = '{32'h00508013, 32'h00000005, 1'b1, 1'b1, ALU_ADD, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000, 1'b0};
        vecs[6]  = '{32'h010000EF, 32'h00000010, 1'b1, 1'b0, ALU_ADD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 3'b000, 1'b0};
        vecs[7]  = '{32'hFE20AC23, 32'hFFFFFFF8, 1'b1, 1'b1, ALU_ADD, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000, 1'b0};
        vecs[8]  = '{32'h4030D293, 32'h00000403, 1'b1, 1'b1, ALU_SRA, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000, 1'b0};
        vecs[9]  = '{32'h0020B1B3, 32'h00000000, 1'b0, 1'b1, 4'b1100, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000, 1'b0};
        vecs[10] = '{32'h40109293, 32'h00000000, 1'b0, 1'b0, ALU_ADD, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000, 1'b1};
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            bus.in_instr = vecs[i].instr; bus.in_pc = 32'h600 + 32'(i * 4);
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL dec%0d_valid got=%0h want=1", i, bus.out_valid); end
            checks++; if (bus.out_illegal !== vecs[i].ill) begin errors++; $display("[TB] FAIL dec%0d_illegal got=%0h want=%0h", i, bus.out_illegal, vecs[i].ill); end
            checks++; if ({bus.out_regwrite, bus.out_memread, bus.out_memwrite, bus.out_branch, bus.out_jump} !== {vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].br, vecs[i].jp})
                begin errors++; $display("[TB] FAIL dec%0d_ctrl got=%b want=%b", i, {bus.out_regwrite, bus.out_memread, bus.out_memwrite, bus.out_branch, bus.out_jump}, {vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].br, vecs[i].jp}); end
            if (vecs[i].chk_imm) begin
                checks++; if (bus.out_imm !== vecs[i].imm) begin errors++; $display("[TB] FAIL dec%0d_imm got=%0h want=%0h", i, bus.out_imm, vecs[i].imm); end
            end
            if (vecs[i].chk_full) begin
                checks++; if (bus.out_aluop !== vecs[i].aluop) begin errors++; $display("[TB] FAIL dec%0d_aluop got=%0h want=%0h", i, bus.out_aluop, vecs[i].aluop); end
                checks++; if (bus.out_alusrc !== vecs[i].alusrc) begin errors++; $display("[TB] FAIL dec%0d_alusrc got=%0h want=%0h", i, bus.out_alusrc, vecs[i].alusrc); end
                checks++; if ({bus.out_memsize, bus.out_memunsigned} !== {vecs[i].ms, vecs[i].mu}) begin errors++; $display("[TB] FAIL dec%0d_mem got=%0h/%0h want=%0h/%0h", i, bus.out_memsize, bus.out_memunsigned, vecs[i].ms, vecs[i].mu); end
                if (vecs[i].br) begin
                    checks++; if (bus.out_brfunct3 !== vecs[i].bf3) begin errors++; $display("[TB] FAIL dec%0d_brfunct3 got=%0h want=%0h", i, bus.out_brfunct3, vecs[i].bf3); end
                end
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = '0; bus.flush = 1'b0;
        bus.ex_load_valid = 1'b0; bus.ex_load_rd = 5'd0; bus.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_load_use();
        test_backpressure();
        test_flush();
        test_decode_table();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered, parametrised successor to the combinational RV32I control decoder.
- Sits between the fetch and execute pipeline stages, with valid/ready handshakes on both sides.
- Adds immediate generation, wider ALU/memory-size encodings (SLT/SLTU, halfword, unsigned loads), an illegal-instruction flag, a load-use interlock and a flush.
- Holds one decoded instruction in an output register.

Parameters:
- XLEN, 32, datapath/immediate/PC width; sign-extension target.
- ALUOP_W, 4, width of ALU operation code; must be ≥4.
- HAZARD_EN, 1, 1 = load-use interlock active; 0 = ex_load_* ignored.
- RESET_PC, 0, value driven on out_pc while out_valid=0 after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- flush  in  1  kill held and incoming instruction (branch redirect).
- ex_load_valid  in  1  execute stage holds a load.
- ex_load_rd  in  5  destination of that load.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_pc  out  XLEN  registered PC.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_aluop  out  ALUOP_W  alu_ops_t code.
- out_alusrc  out  2  00 = rs2, 01 = imm, 10 = upper imm.
- out_regwrite, out_memtoreg, out_memread, out_memwrite, out_branch, out_jump  out  1 each  control bits.
- out_memsize  out  2  00 = byte, 01 = half, 10 = word.
- out_memunsigned  out  1  LBU/LHU.
- out_brfunct3  out  3  branch condition.
- out_illegal  out  1  unsupported opcode/funct.

Interface: one clock (clk); reset is synchronous and active-high (reset).

Behaviour:
- Reset, at the clk edge with reset=1:
  - out_valid=0 and every control bit 0.
  - out_aluop=ADD, out_memsize=10, out_imm=0, out_pc=RESET_PC, indices 0.
  - Reset overrides flush and any handshake in the same cycle.
- Latency: exactly 1 cycle. An instruction accepted at edge N appears on out_* with out_valid=1 after edge N.
- Hazard detection:
  - hazard = HAZARD_EN & ex_load_valid & (ex_load_rd≠0).
  - And ex_load_rd matches in_instr rs1 or rs2, where used. rs1 is used by all types except LUI/AUIPC/JAL. rs2 is used by R, STORE and BRANCH only.
- in_ready = (~out_valid | out_ready) & ~hazard & ~reset.
- Accept = in_valid & in_ready & ~flush. On accept, load the output register and set out_valid=1.
- Output side:
  - If out_ready & out_valid and there is no accept, out_valid→0 (bubble).
  - If out_valid & ~out_ready, the output register holds and all fields stay stable.
- Hazard bubble: when hazard and out_ready, out_valid→0 and the instruction waits at input. Fetch must hold in_instr/in_pc while in_ready=0.
- flush: out_valid→0 next edge. The incoming instruction is not accepted even if in_valid=1. Flush wins over a simultaneous accept and over out_ready=0.
- Decode table:
  - R-type: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - I-ALU: same set minus SUB. Shifts require funct7 ∈ {0000000, 0100000 (SRAI only)}.
  - LOAD: LB/LH/LW/LBU/LHU → memsize/memunsigned.
  - STORE: SB/SH/SW.
  - BRANCH: all six; aluop=SUB, brfunct3=funct3.
  - JAL/JALR: jump=1, regwrite=1.
  - LUI/AUIPC: alusrc=10, imm=instr[31:12]<<12.
- Immediates: I, S, B, U, J formats, sign-extended from bit 31 to XLEN.
- Illegal instruction:
  - Triggered by any other opcode/funct combination. LOAD funct3 011/110/111 and STORE funct3 ≥011 are illegal.
  - out_illegal=1, with regwrite, memwrite, memread, branch and jump all 0. The bundle still flows with out_valid=1.
- Writes to rd=0 decode normally; out_regwrite=0 when rd=0.

Decomposition:
- Package rv_pkg holds:
  - alu_ops_t, extended with SLT=4'b1011 and SLTU=4'b1100.
  - Opcode localparams.
  - memsize_t.
  - A packed struct decode_bundle_t holding all out_* fields except valid.
- One combinational sub-module, rv_decode_comb (instr → decode_bundle_t, plus rs1_used/rs2_used). The stage module adds the register, handshake, interlock and flush.

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1 and in_instr=0x002081B3. Required: out_valid=0, in_ready=0, out_aluop=ADD, out_pc=RESET_PC.
- Stream: 0x402081B3 (SUB) then 0x00812283 (LW x5,8(x2)), out_ready=1. Required, one cycle later each:
  - SUB: aluop=0010, rd=3.
  - LW: memread=1, memtoreg=1, memsize=10, imm=8, alusrc=01.
- Load-use: ex_load_valid=1, ex_load_rd=5, in_instr=0x00128333 (add x6,x5,x1). Required: in_ready=0 and out_valid=0 until ex_load_valid drops; the instruction is then accepted once.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1. Required: outputs stable, in_ready=0, no instruction lost or duplicated.
- Flush: flush=1 while out_valid=1, out_ready=0 and in_valid=1. Required: out_valid=0 next cycle, and the incoming instruction is dropped.
- Immediate/illegal:
  - 0x123450B7 (LUI x1) → imm=0x12345000, alusrc=10.
  - 0xFFFFFFFF → illegal=1, regwrite=0, memwrite=0.
